sprite_row_packer: RTL and testbench
====================================

Name: sprite_row_packer

Overview:
- Write-side counterpart of the 64x64 3-bit sprite renderer.
- Accepts a stream of 3-bit RGB pixels in raster order (row 0 col 0 first) over a valid/ready handshake.
- Packs each row of 64 pixels into a 192-bit word and issues one row write per row to the sprite row memory.
- The resulting memory layout is the one the renderer reads: pixel at column c occupies bits [191-3c -: 3] of row word y.

Parameters:
- SPRITE_W, 64, pixels per row
- SPRITE_H, 64, rows per sprite
- BPP, 3, bits per pixel; row word width = SPRITE_W*BPP = 192

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  one-cycle request to begin loading a sprite; honoured only in IDLE
- pix_valid  input  1  pix_data is valid this cycle
- pix_data  input  3  RGB pixel; 3'b000 is the transparent code and is stored unchanged
- pix_ready  output  1  packer accepts a pixel this cycle
- row_we  output  1  one-cycle write strobe to sprite row memory
- row_addr  output  6  row index being written (log2 SPRITE_H)
- row_data  output  192  packed row word
- busy  output  1  high from accepted start until the DONE cycle inclusive
- done  output  1  one-cycle pulse after the last row write

Behaviour:
- Reset (async, rst=1): state=IDLE; pix_ready=0, row_we=0, row_addr=0, row_data=0, busy=0, done=0; column and row counters=0.
- All outputs are registered except pix_ready, which is decoded from state (high only in FILL).
- States:
  - IDLE:
    - start=1 -> FILL; row=0, col=0, busy=1.
    - Pixels offered in IDLE are not accepted (pix_ready=0).
  - FILL:
    - On each cycle with pix_valid && pix_ready: shift register <= {shift[188:0], pix_data}; col increments.
    - After the 64th accept (col==63 accepted): the next state is WRITE, and row_data <= the fully shifted word, including that last pixel.
    - Net layout: the first accepted pixel of a row lands at bits [191:189], the last at [2:0].
    - pix_valid=0 stalls FILL indefinitely; no timeout.
  - WRITE (exactly one cycle):
    - row_we=1, row_addr=row; pix_ready=0.
    - If row==SPRITE_H-1 -> DONE; otherwise row++, col=0, -> FILL.
  - DONE (one cycle):
    - done=1, busy still 1 -> IDLE; busy falls on the next cycle.
- Latency and throughput:
  - row_we asserts on the cycle after the 64th pixel handshake.
  - At full rate a row takes 65 cycles; a full sprite takes 64*65 cycles.
  - The final done pulse occurs 2 cycles after the last pixel handshake.
- row_addr and row_data hold their last values outside WRITE; they are meaningful only while row_we=1.
- start asserted in FILL/WRITE/DONE is ignored; it does not restart or queue.
- start and pix_valid asserted in the same IDLE cycle: the pixel is not consumed, and the first accept happens the following cycle.
- Counters: col is 6 bits and row is 6 bits. No wrap beyond SPRITE_H-1 is possible because WRITE at the last row exits to DONE.
- Reset mid-operation: all state is discarded immediately; a partially written sprite remains in memory, with no rollback. The next start begins at row 0.
- The packer never issues row_we and done in the same cycle.

Decomposition:
- Shared package/header (sprite_pkg or defines file):
  - SPRITE_W, SPRITE_H, BPP, and the derived ROW_BITS=192.
  - Address width 6 and the state encoding (IDLE=0, FILL=1, WRITE=2, DONE=3).
  - The transparent colour constant 3'b000, so the renderer and the packer agree.
- One natural sub-module: pixel_shift_reg. It is a BPP-wide, SPRITE_W-deep shift register with a shift-enable input and a parallel output. The FSM and counters stay in the top.

Test Plan:
1. Reset then idle:
   - Stimulus: rst pulse with pix_valid=1 held and no start.
   - Required: pix_ready=0, row_we never rises, busy=0, done=0, all outputs 0.
2. Single-row ordering:
   - Stimulus: start, then stream pixel c = c mod 8 for c=0..63 at full rate.
   - Required: row_we=1 on the cycle after the 64th handshake, row_addr=0, row_data[191:189]=3'd0, row_data[188:186]=3'd1, row_data[2:0]=3'd7 (c=63).
3. Full sprite at full rate:
   - Stimulus: row y filled entirely with (y mod 7)+1.
   - Required:
     - 64 row_we pulses with row_addr 0..63 in order.
     - Each row_data equals 64 copies of the value.
     - done pulses exactly once, 4160 cycles after the first handshake (64*65 = 4160).
     - busy falls one cycle after done.
   - Read-back through the renderer model reproduces each pixel.
4. Backpressure and bubbles:
   - Stimulus: pix_valid randomly low about 50% of cycles.
   - Required:
     - The same row words as scenario 3.
     - No pixel is lost or duplicated.
     - pix_ready=0 on every WRITE cycle, and offered pixels there are not consumed.
5. Ignored start:
   - Stimulus: pulse start during row 10 FILL and again during a WRITE cycle.
   - Required: row counter is unaffected, the sequence continues at row 10, and only one done pulse occurs.
6. Reset mid-load:
   - Stimulus: assert rst after 30 pixels of row 5, then start again.
   - Required:
     - Outputs return to 0 asynchronously.
     - The next row_we carries row_addr=0 and row_data built only from post-restart pixels.

Source files
------------

// File: rtl/sprite_row_packer_pkg.sv
// -----------------------------------------------------------------------------
// sprite_row_packer_pkg
// Shared definitions for the 64x64 3-bit sprite path. The renderer and the
// packer both import this package, so they agree on geometry, the row-word
// layout and the transparent colour code.
//
// Contents:
//   SPRITE_W / SPRITE_H / BPP : sprite geometry
//   ROW_BITS                  : packed row word width (SPRITE_W*BPP = 192)
//   ADDR_W / COL_W            : row and column counter widths
//   TRANSPARENT               : colour code treated as transparent by the renderer
//   state_t                   : packer FSM encoding
//   pixel_at()                : extract pixel at a column from a row word
// -----------------------------------------------------------------------------
package sprite_row_packer_pkg;

   localparam int unsigned SPRITE_W = 64;
   localparam int unsigned SPRITE_H = 64;
   localparam int unsigned BPP      = 3;
   localparam int unsigned ROW_BITS = SPRITE_W * BPP;
   localparam int unsigned ADDR_W   = 6;
   localparam int unsigned COL_W    = 6;

   // Stored unchanged by the packer; only the renderer gives it meaning.
   localparam logic [BPP-1:0] TRANSPARENT = '0;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FILL  = 2'd1,
      ST_WRITE = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   // Column c lives at bits [ROW_BITS-1-BPP*c -: BPP] of the row word.
   function automatic logic [BPP-1:0] pixel_at(input logic [ROW_BITS-1:0] word,
                                                input logic [COL_W-1:0]    col);
      logic [ROW_BITS-1:0] shifted;
      shifted = word >> (BPP * (SPRITE_W - 1 - int'(col)));
      return shifted[BPP-1:0];
   endfunction

endpackage

// File: rtl/sprite_row_packer_pixel_shift_reg.sv
// -----------------------------------------------------------------------------
// pixel_shift_reg
// BPP-wide, DEPTH-deep pixel shift register. New pixels enter at the least
// significant end, so after DEPTH shifts the first pixel shifted in occupies
// the most significant BPP bits.
//
// Ports:
//   clk        : clock
//   rst        : asynchronous active-high reset, clears the register
//   shift_en_i : shift pix_i in this cycle
//   pix_i      : incoming pixel
//   next_o     : register contents with pix_i already appended; this is the
//                value loaded on a shift and lets the owner capture a complete
//                row in the same cycle as the last pixel arrives
// -----------------------------------------------------------------------------
module pixel_shift_reg
   import sprite_row_packer_pkg::*;
#(
   parameter int unsigned PIX_BITS = BPP,
   parameter int unsigned DEPTH    = SPRITE_W
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      shift_en_i,
   input  logic [PIX_BITS-1:0]       pix_i,
   output logic [PIX_BITS*DEPTH-1:0] next_o
);

   localparam int unsigned W = PIX_BITS * DEPTH;

   logic [W-1:0] shift_q;

   assign next_o = {shift_q[W-PIX_BITS-1:0], pix_i};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shift_q <= '0;
      end else if (shift_en_i) begin
         shift_q <= next_o;
      end
   end

endmodule

// File: rtl/sprite_row_packer.sv
// -----------------------------------------------------------------------------
// sprite_row_packer
// Write-side counterpart of the sprite renderer. Takes 3-bit pixels in raster
// order over a valid/ready handshake, packs each 64-pixel row into a 192-bit
// word (first pixel of the row in the top bits) and issues one row write per
// row into the sprite row memory.
//
// Ports:
//   clk       : clock
//   rst       : asynchronous active-high reset
//   start     : begin loading a sprite (honoured only when idle)
//   pix_valid : pix_data valid this cycle
//   pix_data  : RGB pixel
//   pix_ready : pixel accepted this cycle when pix_valid is also high
//   row_we    : one-cycle row write strobe
//   row_addr  : row being written (valid with row_we)
//   row_data  : packed row word (valid with row_we)
//   busy      : from accepted start through the done cycle
//   done      : one-cycle pulse after the last row write
// -----------------------------------------------------------------------------
module sprite_row_packer
   import sprite_row_packer_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic                pix_valid,
   input  logic [BPP-1:0]      pix_data,
   output logic                pix_ready,
   output logic                row_we,
   output logic [ADDR_W-1:0]   row_addr,
   output logic [ROW_BITS-1:0] row_data,
   output logic                busy,
   output logic                done
);

   localparam logic [COL_W-1:0]  COL_LAST = COL_W'(SPRITE_W - 1);
   localparam logic [COL_W-1:0]  COL_INC  = COL_W'(1);
   localparam logic [ADDR_W-1:0] ROW_LAST = ADDR_W'(SPRITE_H - 1);
   localparam logic [ADDR_W-1:0] ROW_INC  = ADDR_W'(1);

   state_t                state_q, state_d;
   logic [COL_W-1:0]      col_q, col_d;
   logic [ADDR_W-1:0]     row_q, row_d;
   logic [ADDR_W-1:0]     row_addr_q, row_addr_d;
   logic [ROW_BITS-1:0]   row_data_q, row_data_d;
   logic                  row_we_q;
   logic                  busy_q;
   logic                  done_q;

   logic                  accept;
   logic [ROW_BITS-1:0]   shift_next;

   assign pix_ready = (state_q == ST_FILL);
   assign accept    = pix_ready && pix_valid;

   pixel_shift_reg #(
      .PIX_BITS (BPP),
      .DEPTH    (SPRITE_W)
   ) u_shift (
      .clk        (clk),
      .rst        (rst),
      .shift_en_i (accept),
      .pix_i      (pix_data),
      .next_o     (shift_next)
   );

   always_comb begin
      state_d    = state_q;
      col_d      = col_q;
      row_d      = row_q;
      row_addr_d = row_addr_q;
      row_data_d = row_data_q;

      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_FILL;
               col_d   = '0;
               row_d   = '0;
            end
         end

         ST_FILL: begin
            if (accept) begin
               // col wraps to 0 on the 64th accept, ready for the next row.
               col_d = col_q + COL_INC;
               if (col_q == COL_LAST) begin
                  state_d    = ST_WRITE;
                  row_addr_d = row_q;
                  // Capture includes the pixel arriving this cycle.
                  row_data_d = shift_next;
               end
            end
         end

         ST_WRITE: begin
            if (row_q == ROW_LAST) begin
               state_d = ST_DONE;
            end else begin
               state_d = ST_FILL;
               row_d   = row_q + ROW_INC;
               col_d   = '0;
            end
         end

         ST_DONE: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Strobes are registered from the next state so they line up exactly
   // with the WRITE / DONE cycles.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         col_q      <= '0;
         row_q      <= '0;
         row_addr_q <= '0;
         row_data_q <= '0;
         row_we_q   <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         col_q      <= col_d;
         row_q      <= row_d;
         row_addr_q <= row_addr_d;
         row_data_q <= row_data_d;
         row_we_q   <= (state_d == ST_WRITE);
         busy_q     <= (state_d != ST_IDLE);
         done_q     <= (state_d == ST_DONE);
      end
   end

   assign row_we   = row_we_q;
   assign row_addr = row_addr_q;
   assign row_data = row_data_q;
   assign busy     = busy_q;
   assign done     = done_q;

endmodule

// File: tb/tb_sprite_row_packer.sv
module tb_sprite_row_packer;

   logic         clk;
   logic         rst;
   logic         start;
   logic         pix_valid;
   logic [2:0]   pix_data;
   logic         pix_ready;
   logic         row_we;
   logic [5:0]   row_addr;
   logic [191:0] row_data;
   logic         busy;
   logic         done;

   sprite_row_packer dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .pix_valid (pix_valid),
      .pix_data  (pix_data),
      .pix_ready (pix_ready),
      .row_we    (row_we),
      .row_addr  (row_addr),
      .row_data  (row_data),
      .busy      (busy),
      .done      (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;
   int done_count = 0;
   int unsigned first_hs = 0;

   typedef struct packed {
      logic [5:0]   addr;
      logic [191:0] data;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;

   task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Scoreboard monitor: every row write is compared against the oldest
   // expected row pushed by the stimulus side.
   always @(negedge clk) begin
      if (!rst) begin
         if (row_we) begin
            chk("write_ready_low", pix_ready, 0);
            chk("we_done_exclusive", done, 0);
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_row_we: got write to row %0d expected no write", row_addr);
            end else begin
               mon_e = exp_q.pop_front();
               chk("row_addr", row_addr, mon_e.addr);
               chk("row_data", row_data, mon_e.data);
            end
         end
         if (done) done_count++;
      end
   end

   // Pixel patterns: 0 = column ramp, 1 = (row mod 7)+1 flat, 2 = mixed.
   function automatic logic [2:0] pix_val(input int unsigned mode, input int unsigned y,
                                          input int unsigned c);
      case (mode)
         0:       return 3'(c % 8);
         1:       return 3'((y % 7) + 1);
         default: return 3'((c * 3 + y + 5) % 8);
      endcase
   endfunction

   // Renderer layout: column c at bits [191-3c -: 3].
   function automatic logic [191:0] row_word(input int unsigned mode, input int unsigned y);
      logic [191:0] w;
      w = '0;
      for (int c = 0; c < 64; c++) w[191 - 3*c -: 3] = pix_val(mode, y, c);
      return w;
   endfunction

   task automatic send_pixel(input logic [2:0] v, input bit bubble, input bit pulse_start);
      bit took;
      int unsigned budget;
      if (bubble) begin
         while ($urandom_range(0, 1) == 1) begin
            pix_valid = 1'b0;
            pix_data  = 3'($urandom_range(0, 7));
            @(posedge clk);
            #1;
         end
      end
      pix_data  = v;
      pix_valid = 1'b1;
      start     = pulse_start;
      took      = 1'b0;
      budget    = 0;
      while (!took && budget < 200) begin
         @(negedge clk);
         took = pix_ready;
         @(posedge clk);
         #1;
         start = 1'b0;
         budget++;
      end
      pix_valid = 1'b0;
      if (!took) begin
         checks++;
         errors++;
         $display("FAIL handshake_timeout: got no pix_ready in %0d cycles expected acceptance", budget);
      end
   endtask

   task automatic send_row(input int unsigned mode, input int unsigned y, input int unsigned ncols,
                           input bit push, input bit bubble, input int start_col);
      if (push) exp_q.push_back({6'(y), row_word(mode, y)});
      for (int c = 0; c < int'(ncols); c++) begin
         send_pixel(pix_val(mode, y, c), bubble, c == start_col);
         if (y == 0 && c == 0) first_hs = cyc;
      end
   endtask

   task automatic send_sprite(input int unsigned mode, input bit bubble,
                              input int fill_start_row, input int write_start_row);
      int sc;
      for (int y = 0; y < 64; y++) begin
         sc = -1;
         if (y == 0 || y == write_start_row) sc = 0;
         else if (y == fill_start_row) sc = 20;
         send_row(mode, y, 64, 1'b1, bubble, sc);
      end
   endtask

   // Called right after the last pixel handshake edge.
   task automatic finish_sprite(input bit check_timing);
      @(negedge clk);
      chk("last_row_we", row_we, 1);
      chk("no_done_in_write", done, 0);
      @(negedge clk);
      chk("done_pulse", done, 1);
      chk("busy_in_done", busy, 1);
      // cyc counts edges: first handshake edge is included in first_hs, so the
      // done cycle (64*65 cycles after the first handshake cycle) reads 4159 more.
      if (check_timing) chk("done_latency", 32'(cyc - first_hs), 32'(64 * 65 - 1));
      @(negedge clk);
      chk("done_one_cycle", done, 0);
      chk("busy_after_done", busy, 0);
      chk("ready_after_done", pix_ready, 0);
      chk("done_count", 32'(done_count), 1);
   endtask

   task automatic do_reset();
      @(posedge clk);
      #2 rst = 1'b1;
      repeat (2) @(posedge clk);
      #3 rst = 1'b0;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst       = 1'b0;
      start     = 1'b0;
      pix_valid = 1'b1;
      pix_data  = 3'd5;

      // 1. Reset then idle with pixels offered and no start.
      #2 rst = 1'b1;
      #1;
      chk("rst_pix_ready", pix_ready, 0);
      chk("rst_busy", busy, 0);
      repeat (2) @(posedge clk);
      #3 rst = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk("idle_pix_ready", pix_ready, 0);
         chk("idle_busy", busy, 0);
         chk("idle_done", done, 0);
         chk("idle_row_addr", row_addr, 0);
         chk("idle_row_data", row_data, 0);
      end
      @(posedge clk);
      #1;
      pix_valid = 1'b0;

      // 2. Single row, start together with the first pixel in IDLE.
      send_row(0, 0, 64, 1'b1, 1'b0, 0);
      @(negedge clk);
      chk("t2_row_we", row_we, 1);
      chk("t2_row_addr", row_addr, 0);
      chk("t2_pix0", row_data[191:189], 3'd0);
      chk("t2_pix1", row_data[188:186], 3'd1);
      chk("t2_pix63", row_data[2:0], 3'd7);
      do_reset();

      // 3. Full sprite at full rate.
      done_count = 0;
      send_sprite(1, 1'b0, -1, -1);
      finish_sprite(1'b1);

      // 4. Same sprite with random bubbles.
      done_count = 0;
      send_sprite(1, 1'b1, -1, -1);
      finish_sprite(1'b0);

      // 5. Start pulses during row 10 FILL and during row 20 WRITE are ignored.
      done_count = 0;
      send_sprite(2, 1'b0, 10, 21);
      finish_sprite(1'b1);
      repeat (4) @(negedge clk);
      chk("t5_stays_idle", busy, 0);
      chk("t5_single_done", 32'(done_count), 1);

      // 6. Reset after 30 pixels of row 5, then restart.
      for (int y = 0; y < 5; y++) send_row(2, y, 64, 1'b1, 1'b0, (y == 0) ? 0 : -1);
      send_row(2, 5, 30, 1'b0, 1'b0, -1);
      #3 rst = 1'b1;
      #1;
      chk("t6_async_busy", busy, 0);
      chk("t6_async_addr", row_addr, 0);
      chk("t6_async_data", row_data, 0);
      chk("t6_async_ready", pix_ready, 0);
      chk("t6_async_we", row_we, 0);
      chk("t6_queue_drained", 32'(exp_q.size()), 0);
      repeat (2) @(posedge clk);
      #3 rst = 1'b0;
      @(posedge clk);
      #1;
      send_row(0, 0, 64, 1'b1, 1'b0, 0);
      @(negedge clk);
      chk("t6_restart_we", row_we, 1);
      do_reset();

      chk("scoreboard_empty", 32'(exp_q.size()), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
